// File: rtl/rob_pkg.sv
// rob_pkg: shared constants for the reorder buffer and its clients.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rob_pkg;

  localparam int DEPTH       = 8;
  localparam int TAG_W       = 3;
  localparam int DATA_W      = 32;
  localparam int WA_W        = 4;
  localparam int CDB_W       = 144;

  // Field positions inside the 144-bit common data bus.
  localparam int CDB_VALID   = 3;
  localparam int CDB_TAG_LO  = 0;
  localparam int CDB_DATA_LO = 4;

endpackage

// File: rtl/rob_ptr.sv
// rob_ptr: wrapping TAG_W-bit ring pointer used for ROB head and tail.
// Latency: the new value is visible the cycle after i_inc / i_clr.
// Backpressure: none; the owner gates i_inc.
module rob_ptr
  import rob_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [TAG_W-1:0] o_ptr
);

  logic [TAG_W-1:0] r_ptr;

  // Clear wins over increment; TAG_W-bit overflow provides the 7->0 wrap.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + TAG_W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: 8-entry circular ROB; allocates tags, captures CDB results, retires in order.
// Latency: CDB capture to commit pulse is >= 2 cycles (capture edge, retire edge, registered commit).
// Backpressure: append is dropped while full; the issue stage must stall on full.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic                CLK,
  input  logic                Reset,
  input  logic                append,
  input  logic                NoWrite,
  input  logic [WA_W-1:0]     WA,
  input  logic                flush,
  input  logic [CDB_W-1:0]    CDB,
  input  logic [2*TAG_W-1:0]  query,
  output logic [TAG_W-1:0]    ROBTail,
  output logic                full,
  output logic                empty,
  output logic [1:0]          query_ready,
  output logic [2*DATA_W-1:0] query_value,
  output logic                commit_valid,
  output logic                commit_wen,
  output logic [WA_W-1:0]     commit_WA,
  output logic [DATA_W-1:0]   commit_data,
  output logic [TAG_W-1:0]    commit_tag
);

  // Entry state
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_ready;
  logic [DEPTH-1:0]  r_nowrite;
  logic [WA_W-1:0]   r_wa    [DEPTH];
  logic [DATA_W-1:0] r_value [DEPTH];
  logic [TAG_W:0]    r_count;

  // Registered commit port
  logic              r_commit_valid;
  logic              r_commit_wen;
  logic [WA_W-1:0]   r_commit_wa;
  logic [DATA_W-1:0] r_commit_data;
  logic [TAG_W-1:0]  r_commit_tag;

  logic              w_cdb_vld;
  logic [TAG_W-1:0]  w_cdb_tag;
  logic [DATA_W-1:0] w_cdb_dat;
  logic              w_cdb_unused;
  logic [TAG_W-1:0]  w_head;
  logic [TAG_W-1:0]  w_tail;
  logic              w_full;
  logic              w_alloc;
  logic              w_capture;
  logic              w_retire;
  logic [TAG_W-1:0]  w_qtag [2];

  assign w_cdb_vld    = CDB[CDB_VALID];
  assign w_cdb_tag    = CDB[CDB_TAG_LO +: TAG_W];
  assign w_cdb_dat    = CDB[CDB_DATA_LO +: DATA_W];
  // Upper CDB bits belong to other consumers of the bus.
  assign w_cdb_unused = ^CDB[CDB_W-1:CDB_DATA_LO+DATA_W];

  assign w_qtag[0] = query[TAG_W-1:0];
  assign w_qtag[1] = query[2*TAG_W-1:TAG_W];

  // full is sampled before the edge, so a retire in the same cycle never frees a slot early.
  assign w_full    = (r_count == (TAG_W+1)'(DEPTH));
  assign w_alloc   = append & ~w_full & ~flush;
  assign w_capture = w_cdb_vld & r_busy[w_cdb_tag] & ~flush;
  // Uses ready from before the edge: no same-edge CDB-to-retire bypass.
  assign w_retire  = r_busy[w_head] & r_ready[w_head] & ~flush;

  assign ROBTail = w_tail;
  assign full    = w_full;
  assign empty   = (r_count == '0);

  assign commit_valid = r_commit_valid;
  assign commit_wen   = r_commit_wen;
  assign commit_WA    = r_commit_wa;
  assign commit_data  = r_commit_data;
  assign commit_tag   = r_commit_tag;

  rob_ptr u_head (
    .CLK   (CLK),
    .Reset (Reset),
    .i_inc (w_retire),
    .i_clr (flush),
    .o_ptr (w_head)
  );

  rob_ptr u_tail (
    .CLK   (CLK),
    .Reset (Reset),
    .i_inc (w_alloc),
    .i_clr (flush),
    .o_ptr (w_tail)
  );

  // Busy/ready flags: allocate at tail, mark ready on CDB hit, release head on retire.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_busy  <= '0;
      r_ready <= '0;
    end else if (flush) begin
      r_busy  <= '0;
    end else begin
      if (w_alloc) begin
        r_busy[w_tail]  <= 1'b1;
        r_ready[w_tail] <= 1'b0;
      end
      if (w_capture) begin
        r_ready[w_cdb_tag] <= 1'b1;
      end
      if (w_retire) begin
        r_busy[w_head] <= 1'b0;
      end
    end
  end

  // Payload fields carry no reset; they are only read while the entry is busy.
  always_ff @(posedge CLK) begin
    if (w_alloc) begin
      r_nowrite[w_tail] <= NoWrite;
      r_wa[w_tail]      <= WA;
    end
    if (w_capture) begin
      r_value[w_cdb_tag] <= w_cdb_dat;
    end
  end

  // Occupancy: simultaneous allocate and retire leave the count unchanged.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + (TAG_W+1)'(1);
        2'b01:   r_count <= r_count - (TAG_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Commit port: one-cycle pulse per retire; payload holds between retires.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_commit_valid <= 1'b0;
      r_commit_wen   <= 1'b0;
      r_commit_wa    <= '0;
      r_commit_data  <= '0;
      r_commit_tag   <= '0;
    end else if (w_retire) begin
      r_commit_valid <= 1'b1;
      r_commit_wen   <= ~r_nowrite[w_head];
      r_commit_wa    <= r_wa[w_head];
      r_commit_data  <= r_value[w_head];
      r_commit_tag   <= w_head;
    end else begin
      r_commit_valid <= 1'b0;
      r_commit_wen   <= 1'b0;
    end
  end

  // Operand lookup with CDB forwarding; a non-busy tag reads as not ready with value 0.
  always_comb begin
    query_ready = '0;
    query_value = '0;
    for (int k = 0; k < 2; k++) begin
      if (r_busy[w_qtag[k]]) begin
        if (w_cdb_vld && (w_cdb_tag == w_qtag[k])) begin
          query_ready[k]                   = 1'b1;
          query_value[k*DATA_W +: DATA_W]  = w_cdb_dat;
        end else begin
          query_ready[k]                   = r_ready[w_qtag[k]];
          query_value[k*DATA_W +: DATA_W]  = r_value[w_qtag[k]];
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed plus randomized stimulus against a program-order queue model.
// Latency: expected commits are queued before each edge and checked after it.
// Backpressure: the model drops appends while it holds 8 entries.
module tb_reorder_buffer;

  logic         CLK;
  logic         Reset;
  logic         append;
  logic         NoWrite;
  logic [3:0]   WA;
  logic         flush;
  logic [143:0] CDB;
  logic [5:0]   query;
  logic [2:0]   ROBTail;
  logic         full;
  logic         empty;
  logic [1:0]   query_ready;
  logic [63:0]  query_value;
  logic         commit_valid;
  logic         commit_wen;
  logic [3:0]   commit_WA;
  logic [31:0]  commit_data;
  logic [2:0]   commit_tag;

  reorder_buffer dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .append       (append),
    .NoWrite      (NoWrite),
    .WA           (WA),
    .flush        (flush),
    .CDB          (CDB),
    .query        (query),
    .ROBTail      (ROBTail),
    .full         (full),
    .empty        (empty),
    .query_ready  (query_ready),
    .query_value  (query_value),
    .commit_valid (commit_valid),
    .commit_wen   (commit_wen),
    .commit_WA    (commit_WA),
    .commit_data  (commit_data),
    .commit_tag   (commit_tag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [2:0]  tag;
    logic [3:0]  wa;
    bit          nw;
    bit          rdy;
    logic [31:0] val;
  } ent_t;

  ent_t       rob_q[$];
  ent_t       exp_q[$];
  logic [2:0] next_tag;
  int         n_cmp;
  int         n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_query(input logic [2:0] t, input bit cv, input logic [2:0] ct,
                           input logic [31:0] cd, output bit busy, output bit rdy,
                           output logic [31:0] v);
    busy = 1'b0;
    rdy  = 1'b0;
    v    = '0;
    foreach (rob_q[i]) begin
      if (rob_q[i].tag == t) begin
        busy = 1'b1;
        if (cv && ct == t) begin
          rdy = 1'b1;
          v   = cd;
        end else begin
          rdy = rob_q[i].rdy;
          v   = rob_q[i].val;
        end
      end
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, predict the next edge.
  task automatic step(input bit app, input bit nw, input logic [3:0] wa, input bit fl,
                      input bit cv, input logic [2:0] ct, input logic [31:0] cd,
                      input logic [2:0] qa, input logic [2:0] qb);
    bit          busy;
    bit          rdy;
    logic [31:0] v;
    bit          full_pre;
    bit          ret;
    ent_t        e;
    @(negedge CLK);
    append  = app;
    NoWrite = nw;
    WA      = wa;
    flush   = fl;
    CDB[2:0]     = ct;
    CDB[3]       = cv;
    CDB[35:4]    = cd;
    CDB[67:36]   = $urandom;
    CDB[99:68]   = $urandom;
    CDB[131:100] = $urandom;
    CDB[143:132] = 12'($urandom);
    query = {qb, qa};
    #1;
    chk("ROBTail", 64'(ROBTail), 64'(next_tag));
    chk("full", 64'(full), 64'(rob_q.size() == 8));
    chk("empty", 64'(empty), 64'(rob_q.size() == 0));
    exp_query(qa, cv, ct, cd, busy, rdy, v);
    chk("query_ready_a", 64'(query_ready[0]), 64'(rdy));
    if (rdy || !busy) chk("query_value_a", 64'(query_value[31:0]), 64'(v));
    exp_query(qb, cv, ct, cd, busy, rdy, v);
    chk("query_ready_b", 64'(query_ready[1]), 64'(rdy));
    if (rdy || !busy) chk("query_value_b", 64'(query_value[63:32]), 64'(v));
    // Predict the coming edge.
    if (fl) begin
      rob_q.delete();
      next_tag = 3'd0;
    end else begin
      full_pre = (rob_q.size() == 8);
      ret      = (rob_q.size() > 0) && rob_q[0].rdy;
      if (ret) begin
        e = rob_q.pop_front();
        exp_q.push_back(e);
      end
      if (cv) begin
        foreach (rob_q[i]) begin
          if (rob_q[i].tag == ct) begin
            rob_q[i].rdy = 1'b1;
            rob_q[i].val = cd;
          end
        end
      end
      if (app && !full_pre) begin
        e.tag = next_tag;
        e.wa  = wa;
        e.nw  = nw;
        e.rdy = 1'b0;
        e.val = '0;
        rob_q.push_back(e);
        next_tag = next_tag + 3'd1;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 4'd0, 0, 0, 3'd0, 32'd0, 3'($urandom), 3'($urandom));
  endtask

  task automatic do_reset_mid();
    @(negedge CLK);
    Reset  = 1'b1;
    append = 1'b0;
    flush  = 1'b0;
    CDB    = '0;
    #1;
    rob_q.delete();
    next_tag = 3'd0;
    chk("reset_ROBTail", 64'(ROBTail), 64'(next_tag));
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_full", 64'(full), 64'd0);
    chk("reset_commit_valid", 64'(commit_valid), 64'd0);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  // Monitor: after every edge, compare the commit port with the scoreboard.
  initial begin
    ent_t e;
    forever begin
      @(posedge CLK);
      #2;
      chk("commit_valid", 64'(commit_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (commit_valid) begin
          chk("commit_tag", 64'(commit_tag), 64'(e.tag));
          chk("commit_wen", 64'(commit_wen), 64'(!e.nw));
          chk("commit_WA", 64'(commit_WA), 64'(e.wa));
          chk("commit_data", 64'(commit_data), 64'(e.val));
        end
      end
    end
  end

  initial begin
    logic [2:0] ct;
    bit         cv;
    n_cmp    = 0;
    n_err    = 0;
    next_tag = 3'd0;
    Reset    = 1'b1;
    append   = 1'b0;
    NoWrite  = 1'b0;
    WA       = '0;
    flush    = 1'b0;
    CDB      = '0;
    query    = '0;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("idle_commit_valid", 64'(commit_valid), 64'd0);
    end

    // Out-of-order completion, in-order retire.
    step(1, 0, 4'd5, 0, 0, 3'd0, 32'd0, 3'd0, 3'd1);
    step(1, 0, 4'd9, 0, 0, 3'd0, 32'd0, 3'd0, 3'd1);
    step(0, 0, 4'd0, 0, 1, 3'd1, 32'h0000_BBBB, 3'd0, 3'd1);
    step(0, 0, 4'd0, 0, 1, 3'd0, 32'h0000_AAAA, 3'd0, 3'd1);
    repeat (3) idle();

    // Fill from tag 0, overflow attempt, forwarding query, drain one.
    step(0, 0, 4'd0, 1, 0, 3'd0, 32'd0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) step(1, 0, 4'(i + 2), 0, 0, 3'd0, 32'd0, 3'd0, 3'd1);
    step(1, 0, 4'd15, 0, 1, 3'd2, 32'h0000_1234, 3'd2, 3'd3);
    step(0, 0, 4'd0, 0, 1, 3'd3, 32'h0000_0055, 3'd2, 3'd3);
    step(1, 0, 4'd7, 0, 1, 3'd0, 32'hCAFE_0000, 3'd2, 3'd3);
    step(1, 0, 4'd7, 0, 0, 3'd0, 32'd0, 3'd2, 3'd3);
    step(1, 0, 4'd8, 0, 0, 3'd0, 32'd0, 3'd0, 3'd1);
    idle();

    // NoWrite instruction retires with commit_wen low.
    step(0, 0, 4'd0, 1, 0, 3'd0, 32'd0, 3'd0, 3'd0);
    step(1, 1, 4'd3, 0, 0, 3'd0, 32'd0, 3'd0, 3'd0);
    step(0, 0, 4'd0, 0, 1, 3'd0, 32'hDEAD_BEEF, 3'd0, 3'd0);
    repeat (3) idle();

    // Flush with append and CDB hit in the same cycle, head ready.
    for (int i = 0; i < 4; i++) step(1, 0, 4'(i), 0, 0, 3'd0, 32'd0, 3'd0, 3'd0);
    step(0, 0, 4'd0, 0, 1, next_tag - 3'd4, 32'h1111_0000, 3'd0, 3'd0);
    step(1, 0, 4'd6, 1, 1, next_tag - 3'd3, 32'h2222_0000, 3'd0, 3'd0);
    repeat (3) idle();

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) step(1, 0, 4'(i + 8), 0, 0, 3'd0, 32'd0, 3'd0, 3'd0);
    step(0, 0, 4'd0, 0, 1, 3'd0, 32'h3333_0000, 3'd0, 3'd0);
    do_reset_mid();
    repeat (3) idle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cv = ($urandom_range(0, 9) < 7);
      if (rob_q.size() > 0 && $urandom_range(0, 9) < 8)
        ct = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
      else
        ct = 3'($urandom);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, 4'($urandom),
           $urandom_range(0, 63) == 0, cv, ct, $urandom,
           3'($urandom), 3'($urandom));
    end
    repeat (4) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 8-entry circular reorder buffer for the Tomasulo core.
- Allocates a ROB tag to each issued instruction and publishes it as ROBTail, which the register result-status table latches as the producer index.
- Captures results broadcast on the CDB and retires entries in program order to the register file.
- Serves tag-indexed operand lookups for the issue stage.

Parameters:
- DEPTH, 8, number of ROB entries; fixed to match the 3-bit tag on the CDB.
- TAG_W, 3, ROB tag width (log2 DEPTH).
- DATA_W, 32, result width.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- append  in  1  issue stage requests allocation this cycle.
- NoWrite  in  1  issuing instruction has no register destination.
- WA  in  4  destination register of the issuing instruction.
- flush  in  1  synchronous squash of all entries.
- CDB  in  144  bus fields: [3] valid, [2:0] tag, [35:4] data; [143:36] ignored.
- query  in  6  two operand tags: [2:0] operand A, [5:3] operand B.
- ROBTail  out  3  tag the next accepted append receives.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- query_ready  out  2  per-operand result available.
- query_value  out  64  [31:0] operand A value, [63:32] operand B value.
- commit_valid  out  1  one-cycle retire pulse.
- commit_wen  out  1  retire writes the register file (~NoWrite of the retired entry).
- commit_WA  out  4  retire destination register.
- commit_data  out  32  retire value.
- commit_tag  out  3  tag of the retired entry.

Behaviour:
- State:
  - Per entry: busy, ready, nowrite, wa[3:0], value[31:0].
  - head[2:0], tail[2:0], count[3:0].
- Reset (async), all to zero:
  - busy, ready, head, tail, count, commit_valid, commit_wen, commit_WA, commit_data, commit_tag.
  - Hence ROBTail=0, empty=1, full=0.
- ROBTail = tail, combinational. full and empty decode count combinationally.
- Allocate: at the edge with append & ~full:
  - entry[tail] gets busy=1, ready=0, nowrite=NoWrite, wa=WA.
  - tail wraps 7->0.
  - append while full is dropped with no state change; the issue stage must stall on full.
- CDB capture: at the edge with CDB[3] & busy[CDB[2:0]]:
  - ready=1, value=CDB[35:4].
  - CDB to a non-busy tag is ignored.
- Retire: at the edge, if busy[head] & ready[head]:
  - busy[head]=0, head wraps.
  - commit_valid<=1, commit_wen<=~nowrite, commit_WA<=wa, commit_data<=value, commit_tag<=head.
  - Otherwise commit_valid<=0 and commit_wen<=0; the other commit fields hold.
  - At most one retire per cycle.
- Timing:
  - Latency from CDB capture of the head entry to the retire edge is at least 1 cycle; there is no same-edge CDB-to-commit bypass.
  - commit_* is registered, so the pulse appears the cycle after the retire edge.
- count update: +1 on accepted allocate, -1 on retire, unchanged if both or neither occur.
- Full with simultaneous retire: full is evaluated before the edge, so the append is still rejected.
- Allocation into the slot being retired in the same cycle cannot occur, because full blocks it.
- Query (combinational), per operand with tag t:
  - If CDB[3] & CDB[2:0]==t & busy[t]: ready=1, value=CDB data (forwarding).
  - Else ready = busy[t] & ready[t], value = value[t].
  - Non-busy tag: ready=0, value=don't care, driven as 0.
- flush (synchronous):
  - Overrides append, CDB and retire.
  - Clears all busy, head=tail=count=0, commit_valid=0, commit_wen=0.
- Reset asserted mid-operation discards all in-flight entries immediately; no commit pulse is emitted.

Decomposition:
- Shared package rob_pkg holds:
  - constants DEPTH, TAG_W, DATA_W;
  - CDB field positions: CDB_VALID=3, CDB_TAG_LO=0, CDB_DATA_LO=4.
- Register result status and reservation stations import the same package.
- One natural sub-module: rob_ptr, a wrapping TAG_W-bit pointer with increment enable and synchronous clear, instantiated for head and tail.

Test Plan:
- Reset then idle -> ROBTail=0, empty=1, full=0, commit_valid=0 for 5 cycles.
- Append WA=5 then WA=9 (NoWrite=0); CDB tag1 data=0xBBBB, next cycle tag0 data=0xAAAA -> first commit after tag0 capture: commit_tag=0, WA=5, data=0xAAAA; next cycle commit_tag=1, WA=9, data=0xBBBB. Results are in order despite out-of-order completion.
- Append 8 entries -> full=1, ROBTail=0 (wrapped); 9th append ignored; resolve tag0 -> retire occurs, full drops the following cycle, next append gets tag 0.
- Query A=2, B=3 with entry 2 ready value=0x1234 and CDB broadcasting tag3 data=0x55 in the same cycle -> query_ready=2'b11, query_value={0x00000055,0x00001234}.
- Append with NoWrite=1, CDB resolves it -> commit_valid=1, commit_wen=0.
- 4 entries in flight, flush asserted alongside append and a CDB hit -> next cycle empty=1, ROBTail=0, no commit pulse. Repeat with Reset asserted mid-stream -> same result asynchronously.
